adder_rr_arbiter: RTL and testbench

- Shares one registered `adder` datapath between NUM_REQ requesters using round-robin arbitration.
- Accepts at most one operand pair per cycle and drives it into the adder's a/b/valid inputs.
- Tracks the requester ID of every in-flight operation and returns each sum to the requester that issued it.
- Sits between the requester-side agents and the adder instance in the top-level datapath.

---
 rtl/adder_arb_pkg.sv | 28 ++
 rtl/rr_grant.sv | 44 ++++
 rtl/adder_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_adder_rr_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_arb_pkg
//   Shared definitions for the round-robin adder arbiter:
//     - default requester count and operand width
//     - requester ID width and the {vld, id} tag carried alongside each
//       in-flight operation
//     - width of the issue counter and its saturating-increment helper
// -----------------------------------------------------------------------------
package adder_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 8;

  localparam int unsigned ID_W        = $clog2(DEF_NUM_REQ);

  localparam int unsigned ISSUE_CNT_W = 16;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } arb_tag_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ISSUE_CNT_W-1:0] sat_inc(input logic [ISSUE_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
//   Purely combinational round-robin picker. The search starts at ptr and
//   walks ptr, ptr+1, ... modulo NUM_REQ. The first requester found with
//   req_valid set wins.
//
//   Ports:
//     req_valid  in   NUM_REQ  pending requests
//     ptr        in   SEL_W    requester that has highest priority this cycle
//     grant      out  NUM_REQ  one-hot grant (all zero when nothing pending)
//     grant_idx  out  SEL_W    binary index of the granted requester
//                              (0 when nothing pending)
// -----------------------------------------------------------------------------
module rr_grant
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned SEL_W   = ID_W
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   grant_idx
);

  logic [SEL_W-1:0] pos;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = SEL_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
//   Shares one registered adder between NUM_REQ requesters. One operand pair
//   is accepted per cycle under round-robin arbitration, registered onto the
//   adder inputs, and the requester ID travels down a tag pipeline so the
//   sum can be routed back to the requester that issued it.
//
//   Ports:
//     clk        in   1                 rising-edge clock
//     reset      in   1                 asynchronous reset, active low
//     req_valid  in   NUM_REQ           per-requester request
//     req_ready  out  NUM_REQ           one-hot grant (combinational)
//     req_a      in   NUM_REQ*DATA_W    packed operand A, slice i = requester i
//     req_b      in   NUM_REQ*DATA_W    packed operand B
//     rsp_valid  out  NUM_REQ           one-cycle result pulse to the issuer
//     rsp_data   out  DATA_W+1          sum including carry
//     add_valid  out  1                 to adder valid
//     add_a      out  DATA_W            to adder a
//     add_b      out  DATA_W            to adder b
//     add_c      in   DATA_W+1          from adder c
//     issue_cnt  out  16                saturating count of fired requests
//
//   Timing (fire in cycle T):
//     T+1           add_valid/add_a/add_b presented to the adder
//     T+1+ADDER_LAT adder result on add_c, tag pipe tail holds {1, id}
//     T+2+ADDER_LAT rsp_valid[id] and rsp_data
// -----------------------------------------------------------------------------
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDER_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W:0]           rsp_data,
  output logic                      add_valid,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W:0]           add_c,
  output logic [ISSUE_CNT_W-1:0]    issue_cnt
);

  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Tail entry lines up with the cycle in which add_c carries the result.
  localparam int unsigned DEPTH = ADDER_LAT + 1;

  // Same layout as arb_tag_t, but sized from this instance's NUM_REQ so
  // non-default requester counts still carry a wide enough ID.
  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] id;
  } tag_t;

  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   grant_idx;
  logic               fire;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  tag_t               tag_pipe [DEPTH];
  tag_t               tail;
  logic [NUM_REQ-1:0] tail_onehot;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr_grant (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is masked while reset is asserted so nothing appears ready.
  assign req_ready = reset ? grant : '0;
  assign fire      = |(req_valid & req_ready);

  assign ptr_next  = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  assign sel_a     = req_a[grant_idx*DATA_W +: DATA_W];
  assign sel_b     = req_b[grant_idx*DATA_W +: DATA_W];

  assign tail        = tag_pipe[DEPTH-1];
  assign tail_onehot = NUM_REQ'(1) << tail.id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      issue_cnt <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      // Issue stage
      add_valid <= fire;
      if (fire) begin
        ptr       <= ptr_next;
        add_a     <= sel_a;
        add_b     <= sel_b;
        issue_cnt <= sat_inc(issue_cnt);
      end

      // Tag pipeline: never stalls, so IDs stay aligned with adder results.
      tag_pipe[0].vld <= fire;
      tag_pipe[0].id  <= grant_idx;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end

      // Response stage
      rsp_valid <= tail.vld ? tail_onehot : '0;
      if (tail.vld) begin
        rsp_data <= add_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_rr_arbiter
//   Directed bench for adder_rr_arbiter (NUM_REQ=4, DATA_W=8, ADDER_LAT=1).
//   A one-cycle registered adder stands in for the real datapath. Each cycle
//   the bench supplies the request vector and the grant it expects; issue
//   and response expectations follow from those grants three cycles later.
// -----------------------------------------------------------------------------
module tb_adder_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW:0]       rsp_data;
  logic              add_valid;
  logic [DW-1:0]     add_a;
  logic [DW-1:0]     add_b;
  logic [DW:0]       add_c;
  logic [15:0]       issue_cnt;

  logic [DW-1:0]     a_v [NREQ];
  logic [DW-1:0]     b_v [NREQ];

  // Expected-traffic delay line: index 0 = fired last cycle, 2 = three ago.
  logic [NREQ-1:0]   dl_mask [3];
  logic [DW-1:0]     dl_a    [3];
  logic [DW-1:0]     dl_b    [3];
  logic [DW:0]       dl_sum  [3];
  logic [15:0]       exp_cnt;

  int n_checks;
  int n_errors;

  adder_rr_arbiter #(
    .NUM_REQ   (NREQ),
    .DATA_W    (DW),
    .ADDER_LAT (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .add_valid (add_valid),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .issue_cnt (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered adder.
  always_ff @(posedge clk) begin
    if (add_valid) add_c <= {1'b0, add_a} + {1'b0, add_b};
  end

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = a_v[i];
      req_b[i*DW +: DW] = b_v[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      dl_mask[i] = '0;
      dl_a[i]    = '0;
      dl_b[i]    = '0;
      dl_sum[i]  = '0;
    end
    exp_cnt = '0;
  endtask

  // Called at posedge+1. Asserts reset with all requests raised, checks the
  // cleared state, then releases reset with no requests pending.
  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '1;
    clear_model();
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data,  0);
    check("rst_add_valid", add_valid, 0);
    check("rst_add_a",     add_a,     0);
    check("rst_add_b",     add_b,     0);
    check("rst_issue_cnt", issue_cnt, 0);
    req_valid = '0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive rv, expect grant exp_gnt, and check issue /
  // response traffic implied by grants of earlier cycles.
  task automatic cycle(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] exp_gnt);
    int idx;
    req_valid = rv;
    @(negedge clk);
    check("req_ready", req_ready, exp_gnt);
    check("add_valid", add_valid, dl_mask[0] != 0);
    if (dl_mask[0] != 0) begin
      check("add_a", add_a, dl_a[0]);
      check("add_b", add_b, dl_b[0]);
    end
    check("rsp_valid", rsp_valid, dl_mask[2]);
    if (dl_mask[2] != 0) check("rsp_data", rsp_data, dl_sum[2]);
    check("issue_cnt", issue_cnt, exp_cnt);

    for (int i = 2; i > 0; i--) begin
      dl_mask[i] = dl_mask[i-1];
      dl_a[i]    = dl_a[i-1];
      dl_b[i]    = dl_b[i-1];
      dl_sum[i]  = dl_sum[i-1];
    end
    idx = 0;
    for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) idx = i;
    dl_mask[0] = exp_gnt;
    dl_a[0]    = a_v[idx];
    dl_b[0]    = b_v[idx];
    dl_sum[0]  = {1'b0, a_v[idx]} + {1'b0, b_v[idx]};
    if (exp_gnt != 0 && exp_cnt != 16'hFFFF) exp_cnt++;

    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single request: 3 + 5 from requester 0, response 8 three cycles later.
    a_v[0] = 8'd3;
    b_v[0] = 8'd5;
    cycle(4'b0001, 4'b0001);
    drain(4);

    // All four requesting from reset: grants 0,1,2,3,0,1,2,3, sums 11..14.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 8'(i + 1);
      b_v[i] = 8'd10;
    end
    for (int k = 0; k < 8; k++) cycle(4'b1111, 4'(1 << (k % 4)));
    drain(4);

    // Carry out and back-to-back fires from one requester (ptr now 0).
    a_v[2] = 8'd255; b_v[2] = 8'd1;   cycle(4'b0100, 4'b0100);
    a_v[2] = 8'd200; b_v[2] = 8'd100; cycle(4'b0100, 4'b0100);
    a_v[2] = 8'd7;   b_v[2] = 8'd8;   cycle(4'b0100, 4'b0100);
    drain(4);

    // Fairness: ptr is 3. req1/req3 alternate, then req0 joins.
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 8'(16 * i + 1);
      b_v[i] = 8'(100 + i);
    end
    cycle(4'b1010, 4'b1000);
    cycle(4'b1010, 4'b0010);
    cycle(4'b1010, 4'b1000);
    cycle(4'b1010, 4'b0010);
    cycle(4'b1011, 4'b1000);
    cycle(4'b1011, 4'b0001);
    cycle(4'b1011, 4'b0010);
    cycle(4'b1011, 4'b1000);
    drain(4);

    // Reset while an operation is in flight; nothing may come back and the
    // search restarts at requester 0.
    cycle(4'b0100, 4'b0100);
    do_reset();
    drain(4);
    cycle(4'b1111, 4'b0001);
    drain(4);

    // Counter saturation under a sustained stream.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 8'(60 * i + 7);
      b_v[i] = 8'(200 - i);
    end
    for (int n = 0; n < 65540; n++) cycle(4'b1111, 4'(1 << (n % 4)));
    drain(4);
    check("issue_cnt_sat", issue_cnt, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
